hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised forwarding/stall unit for the in-order pipelined core; replaces the fixed three-slot forwarding logic.
- Holds a shift register of in-flight destination writes, one slot per stage after decode.
- From that history it produces per-source forwarding selects and a load-use stall for the instruction in decode.
- Sits beside the decode stage. Generalises pipeline depth, source count, load-ready stage and register-file write-through, and adds flush and a stall counter.

Parameters:
- DEPTH, 3, number of tracked stages after ID (slot 0 = EX, slot DEPTH-1 = WB).
- NUM_SRC, 2, number of source operands checked per decoded instruction.
- REG_AW, 5, register address width.
- LOAD_READY, 1, first slot index whose forwarded value is valid for a load (1 = M-stage output).
- RF_WRITE_THROUGH, 0, when 1 the register file bypasses same-cycle writes, so the last slot is never forwarded.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- id_valid  in  1  decode holds a real instruction.
- id_rs_addr  in  NUM_SRC*REG_AW  source addresses; source i occupies bits [i*REG_AW +: REG_AW].
- id_use_rs  in  NUM_SRC  source i is actually read.
- id_rd_addr  in  REG_AW  destination address.
- id_wb_en  in  1  instruction writes rd.
- id_wb_from_mem  in  1  rd comes from memory (load).
- flush  in  1  kill decode and slots 0..DEPTH-2 (redirect).
- fwd_sel  out  NUM_SRC*(DEPTH+1)  one-hot per source; bit 0 = register file, bit k+1 = slot k.
- stall  out  1  hold PC and IF/ID; a bubble is inserted into slot 0.
- slot_busy  out  DEPTH  per-slot valid-and-writes, for debug.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- State: per slot k, valid, wr_en, rd, from_mem. Every slot advances each cycle: slot k+1 <= slot k.
- Slot 0 loading:
  - If id_valid && !stall && !flush, slot 0 <= decode fields.
  - Otherwise slot 0 <= bubble (valid=0).
- Flush: on the clock edge with flush=1, slots 1..DEPTH-1 <= shifted slots 0..DEPTH-2 with valid forced to 0. The slot DEPTH-1 contents that were about to retire still retire.
- Match for source i at slot k:
  - Requires id_use_rs[i], valid_k, wr_en_k, rd_k == rs_i, and rs_i != 0. x0 never matches.
  - When RF_WRITE_THROUGH=1, slot DEPTH-1 is excluded.
- Forward select (combinational, same cycle): per source, the lowest-index (youngest) matching slot wins. No match gives bit 0. Exactly one bit set is an invariant.
- Stall: asserted combinationally when id_valid && !flush and any source's winning slot k has from_mem_k=1 and k < LOAD_READY. Flush has priority over stall.
- While stalled, fwd_sel is still driven but is don't-care to the consumer.
- stall_count increments on every cycle with stall=1 and saturates at all-ones.
- Reset (rst low, asynchronous):
  - All slot valid bits clear; fields zero.
  - stall_count = 0; stall = 0; fwd_sel = register file for every source; slot_busy = 0.
  - Reset mid-stall drops the pending load immediately.
  - The first edge after release may load slot 0.
- Latency: slot k is occupied by the instruction decoded k+1 cycles earlier, minus inserted bubbles.

Decomposition:
- Package hazard_pkg: slot struct (valid, wr_en, rd, from_mem); function for the one-hot select width; constant REG_ZERO.
- One sub-module, hazard_match: one source against all slots. Combinational priority encoder giving the one-hot select and a load-hit flag. Instantiated NUM_SRC times via generate.

Test Plan:
- Defaults; issue "add x5" then "add x6,x5,x5" next cycle -> fwd_sel src0 = src1 = 4'b0010 (slot 0), stall=0.
- "lw x7" then "add x8,x7,x0" next cycle -> stall=1 for exactly 1 cycle. Next cycle fwd_sel src0 = 4'b0100 (slot 1); src1 = 4'b0001 (x0). stall_count=1.
- "add x9" in slot 0 and an older "add x9" in slot 2; decode reads x9 -> slot 0 wins, fwd_sel = 4'b0010.
- RF_WRITE_THROUGH=1; only slot 2 writes x3; decode reads x3 -> fwd_sel = 4'b0001.
- "lw x4" in slot 0 with flush=1 while decode reads x4 -> stall=0. After the edge, slot_busy = 3'b000 and no forwarding from the flushed load.
- Assert rst low asynchronously mid-cycle with 3 busy slots and stall_count=5 -> outputs reset immediately. Across DEPTH=5, NUM_SRC=3, fwd_sel stays one-hot for every source every cycle under random stimulus.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: in-flight slot record,
// select-width helper and the hard-wired zero register address.
package hazard_pkg;

    // Slot rd field is stored at a fixed width; narrower register
    // addresses are zero-extended into it.
    localparam int RD_MAX_W = 8;

    localparam logic [RD_MAX_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                valid;
        logic                wr_en;
        logic [RD_MAX_W-1:0] rd;
        logic                from_mem;
    } slot_t;

    // One-hot select: register file plus one bit per tracked slot.
    function automatic int sel_width(input int depth);
        return depth + 1;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// One source operand checked against every in-flight slot.
// Ports: use_rs/rs (source), slots (history), sel (one-hot), load_hit.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int DEPTH            = 3,
    parameter int LOAD_READY       = 1,
    parameter int RF_WRITE_THROUGH = 0
) (
    input  logic                use_rs,
    input  logic [RD_MAX_W-1:0] rs,
    input  slot_t [DEPTH-1:0]   slots,
    output logic [DEPTH:0]      sel,
    output logic                load_hit
);

    logic [DEPTH-1:0] hit;
    logic             found;

    always_comb begin
        hit = '0;
        for (int k = 0; k < DEPTH; k++) begin
            hit[k] = use_rs && slots[k].valid && slots[k].wr_en &&
                     (slots[k].rd == rs) && (rs != REG_ZERO);
            // With write-through the RF already returns the value
            // retiring from the last slot.
            if (RF_WRITE_THROUGH != 0 && k == DEPTH-1) begin
                hit[k] = 1'b0;
            end
        end
    end

    // Youngest (lowest index) match wins.
    always_comb begin
        sel      = '0;
        load_hit = 1'b0;
        found    = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (hit[k] && !found) begin
                found    = 1'b1;
                sel[k+1] = 1'b1;
                load_hit = slots[k].from_mem && (k < LOAD_READY);
            end
        end
        sel[0] = !found;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Forwarding-select and load-use stall unit beside decode.
// Ports: id_* (decode fields), flush, fwd_sel, stall, slot_busy, stall_count.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH            = 3,
    parameter int NUM_SRC          = 2,
    parameter int REG_AW           = 5,
    parameter int LOAD_READY       = 1,
    parameter int RF_WRITE_THROUGH = 0,
    parameter int CNT_W            = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]         id_rs_addr,
    input  logic [NUM_SRC-1:0]                id_use_rs,
    input  logic [REG_AW-1:0]                 id_rd_addr,
    input  logic                              id_wb_en,
    input  logic                              id_wb_from_mem,
    input  logic                              flush,
    output logic [NUM_SRC*sel_width(DEPTH)-1:0] fwd_sel,
    output logic                              stall,
    output logic [DEPTH-1:0]                  slot_busy,
    output logic [CNT_W-1:0]                  stall_count
);

    slot_t [DEPTH-1:0] slots;
    slot_t             dec;
    logic [NUM_SRC-1:0] load_hit;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hazard_match #(
            .DEPTH            (DEPTH),
            .LOAD_READY       (LOAD_READY),
            .RF_WRITE_THROUGH (RF_WRITE_THROUGH)
        ) u_match (
            .use_rs   (id_use_rs[i]),
            .rs       (RD_MAX_W'(id_rs_addr[i*REG_AW +: REG_AW])),
            .slots    (slots),
            .sel      (fwd_sel[i*(DEPTH+1) +: DEPTH+1]),
            .load_hit (load_hit[i])
        );
    end

    // Flush outranks the load-use hazard.
    assign stall = id_valid && !flush && (|load_hit);

    always_comb begin
        dec.valid    = id_valid && !stall && !flush;
        dec.wr_en    = id_wb_en;
        dec.rd       = RD_MAX_W'(id_rd_addr);
        dec.from_mem = id_wb_from_mem;
    end

    always_comb begin
        slot_busy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot_busy[k] = slots[k].valid && slots[k].wr_en;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slots       <= '0;
            stall_count <= '0;
        end else begin
            slots[0] <= dec.valid ? dec : '0;
            // The oldest slot retires regardless; everything younger
            // is killed on the way down when flushing.
            for (int k = 1; k < DEPTH; k++) begin
                slots[k] <= slots[k-1];
                if (flush) begin
                    slots[k].valid <= 1'b0;
                end
            end
            if (stall && stall_count != '1) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed table plus corner sequences for hazard_scoreboard.
// Three instances: defaults, write-through, deep/wide with narrow counter.
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: defaults
    logic       v0, wb0, mem0, fl0;
    logic [9:0] rs0;
    logic [1:0] use0;
    logic [4:0] rd0;
    logic [7:0] fwd0;
    logic       stall0;
    logic [2:0] busy0;
    logic [31:0] cnt0;

    // Instance 1: register file write-through
    logic       v1, wb1, mem1, fl1;
    logic [9:0] rs1;
    logic [1:0] use1;
    logic [4:0] rd1;
    logic [7:0] fwd1;
    logic       stall1;
    logic [2:0] busy1;
    logic [31:0] cnt1;

    // Instance 2: DEPTH=5, NUM_SRC=3, LOAD_READY=3, CNT_W=3
    logic        v2, wb2, mem2, fl2;
    logic [14:0] rs2;
    logic [2:0]  use2;
    logic [4:0]  rd2;
    logic [17:0] fwd2;
    logic        stall2;
    logic [4:0]  busy2;
    logic [2:0]  cnt2;

    hazard_scoreboard u0 (
        .clk(clk), .rst(rst), .id_valid(v0), .id_rs_addr(rs0),
        .id_use_rs(use0), .id_rd_addr(rd0), .id_wb_en(wb0),
        .id_wb_from_mem(mem0), .flush(fl0), .fwd_sel(fwd0),
        .stall(stall0), .slot_busy(busy0), .stall_count(cnt0)
    );

    hazard_scoreboard #(.RF_WRITE_THROUGH(1)) u1 (
        .clk(clk), .rst(rst), .id_valid(v1), .id_rs_addr(rs1),
        .id_use_rs(use1), .id_rd_addr(rd1), .id_wb_en(wb1),
        .id_wb_from_mem(mem1), .flush(fl1), .fwd_sel(fwd1),
        .stall(stall1), .slot_busy(busy1), .stall_count(cnt1)
    );

    hazard_scoreboard #(
        .DEPTH(5), .NUM_SRC(3), .LOAD_READY(3), .CNT_W(3)
    ) u2 (
        .clk(clk), .rst(rst), .id_valid(v2), .id_rs_addr(rs2),
        .id_use_rs(use2), .id_rd_addr(rd2), .id_wb_en(wb2),
        .id_wb_from_mem(mem2), .flush(fl2), .fwd_sel(fwd2),
        .stall(stall2), .slot_busy(busy2), .stall_count(cnt2)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive0(input logic v, input logic [4:0] a,
                          input logic [4:0] b, input logic [1:0] u,
                          input logic [4:0] rd, input logic wb,
                          input logic mem, input logic fl);
        v0 = v; rs0 = {b, a}; use0 = u; rd0 = rd;
        wb0 = wb; mem0 = mem; fl0 = fl;
    endtask

    typedef struct {
        logic        v;
        logic [4:0]  a, b;
        logic [1:0]  u;
        logic [4:0]  rd;
        logic        wb, mem, fl;
        logic [7:0]  fwd;
        logic        st;
        logic [2:0]  busy;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(
        input logic v, input logic [4:0] a, input logic [4:0] b,
        input logic [1:0] u, input logic [4:0] rd, input logic wb,
        input logic mem, input logic fl, input logic [7:0] fwd,
        input logic st, input logic [2:0] busy, input logic [31:0] cnt);
        vec_t r;
        r.v = v; r.a = a; r.b = b; r.u = u; r.rd = rd;
        r.wb = wb; r.mem = mem; r.fl = fl;
        r.fwd = fwd; r.st = st; r.busy = busy; r.cnt = cnt;
        return r;
    endfunction

    initial begin
        //             v  a  b  u  rd  wb m  fl  fwd    st busy    cnt
        tbl[0]  = mk(1, 1, 2, 0, 5,  1, 0, 0, 8'h11, 0, 3'b000, 0);
        tbl[1]  = mk(1, 5, 5, 3, 6,  1, 0, 0, 8'h22, 0, 3'b001, 0);
        tbl[2]  = mk(1, 6, 0, 1, 7,  1, 1, 0, 8'h12, 0, 3'b011, 0);
        tbl[3]  = mk(1, 7, 0, 3, 8,  1, 0, 0, 8'h12, 1, 3'b111, 0);
        tbl[4]  = mk(1, 7, 0, 3, 8,  1, 0, 0, 8'h14, 0, 3'b110, 1);
        tbl[5]  = mk(1, 8, 0, 1, 9,  1, 0, 0, 8'h12, 0, 3'b101, 1);
        tbl[6]  = mk(1, 0, 0, 0, 10, 1, 0, 0, 8'h11, 0, 3'b011, 1);
        tbl[7]  = mk(1, 0, 0, 0, 9,  1, 0, 0, 8'h11, 0, 3'b111, 1);
        tbl[8]  = mk(1, 9, 9, 3, 0,  0, 0, 0, 8'h22, 0, 3'b111, 1);
        tbl[9]  = mk(0, 9, 10, 2, 0, 0, 0, 0, 8'h81, 0, 3'b110, 1);
        tbl[10] = mk(0, 9, 0, 3, 0,  0, 0, 0, 8'h18, 0, 3'b100, 1);
        tbl[11] = mk(1, 0, 0, 0, 4,  1, 1, 0, 8'h11, 0, 3'b000, 1);
        tbl[12] = mk(1, 4, 0, 1, 0,  0, 0, 1, 8'h12, 0, 3'b001, 1);
        tbl[13] = mk(1, 4, 0, 1, 0,  0, 0, 0, 8'h11, 0, 3'b000, 1);

        drive0(0, 0, 0, 0, 0, 0, 0, 0);
        v1 = 0; rs1 = '0; use1 = '0; rd1 = '0; wb1 = 0; mem1 = 0; fl1 = 0;
        v2 = 0; rs2 = '0; use2 = '0; rd2 = '0; wb2 = 0; mem2 = 0; fl2 = 0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_fwd", 32'(fwd0), 32'h11);
        chk("rst_stall", 32'(stall0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_cnt", cnt0, 0);
        rst = 1'b1;

        // Directed table on the default instance
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive0(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].u, tbl[i].rd,
                   tbl[i].wb, tbl[i].mem, tbl[i].fl);
            #1;
            chk($sformatf("tbl%0d_fwd", i), 32'(fwd0), 32'(tbl[i].fwd));
            chk($sformatf("tbl%0d_stall", i), 32'(stall0), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_busy", i), 32'(busy0), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_cnt", i), cnt0, tbl[i].cnt);
        end

        // Write-through: last slot never forwarded
        @(negedge clk);
        v1 = 1; rd1 = 5'd3; wb1 = 1; use1 = 2'b00;
        @(negedge clk);
        v1 = 0; rs1 = {5'd0, 5'd3}; use1 = 2'b01; wb1 = 0; rd1 = 0;
        #1 chk("wt_slot0", 32'(fwd1[3:0]), 32'h2);
        @(negedge clk);
        #1 chk("wt_slot1", 32'(fwd1[3:0]), 32'h4);
        @(negedge clk);
        #1;
        chk("wt_slot2_rf", 32'(fwd1[3:0]), 32'h1);
        chk("wt_slot2_busy", 32'(busy1), 32'b100);

        // Late load-ready: 3 stall cycles per load-use, counter saturates
        for (int r = 0; r < 3; r++) begin
            int st;
            st = 0;
            @(negedge clk);
            v2 = 1; rd2 = 5'd1; wb2 = 1; mem2 = 1; use2 = 3'b000;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                v2 = 1; rs2 = 15'd1; use2 = 3'b001;
                rd2 = 5'd2; wb2 = 0; mem2 = 0;
                #1;
                if (stall2) st++;
            end
            chk($sformatf("lr_stall_len%0d", r), 32'(st), 3);
            if (r == 0) chk("lr_cnt3", 32'(cnt2), 3);
        end
        chk("sat_cnt", 32'(cnt2), 7);

        // Random stimulus: one-hot select, flush beats stall
        for (int n = 0; n < 300; n++) begin
            logic ok;
            @(negedge clk);
            v2 = 1'($urandom);
            rs2 = 15'($urandom);
            use2 = 3'($urandom);
            rd2 = 5'($urandom_range(0, 7));
            rs2[4:0] = 5'($urandom_range(0, 7));
            wb2 = 1'($urandom);
            mem2 = 1'($urandom);
            fl2 = ($urandom_range(0, 7) == 0);
            #1;
            ok = 1'b1;
            for (int s = 0; s < 3; s++) begin
                if (!$onehot(fwd2[s*6 +: 6])) ok = 1'b0;
            end
            chk($sformatf("rand%0d_onehot", n), 32'(ok), 1);
            if (fl2) chk($sformatf("rand%0d_flush", n), 32'(stall2), 0);
        end
        fl2 = 0;
        #1 chk("sat_hold", 32'(cnt2), 7);

        // Build stall_count=5 with busy slots and a pending load-use
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            drive0(1, 0, 0, 0, 7, 1, 1, 0);
            @(negedge clk);
            drive0(1, 7, 0, 3, 8, 1, 0, 0);
            @(negedge clk);
        end
        @(negedge clk);
        drive0(1, 0, 0, 0, 11, 1, 0, 0);
        @(negedge clk);
        drive0(1, 0, 0, 0, 12, 1, 0, 0);
        @(negedge clk);
        drive0(1, 0, 0, 0, 13, 1, 1, 0);
        @(negedge clk);
        drive0(1, 13, 0, 1, 14, 1, 0, 0);
        #1;
        chk("pre_rst_stall", 32'(stall0), 1);
        chk("pre_rst_busy", 32'(busy0), 32'b111);
        chk("pre_rst_cnt", cnt0, 5);
        #1 rst = 1'b0;
        #1;
        chk("async_stall", 32'(stall0), 0);
        chk("async_busy", 32'(busy0), 0);
        chk("async_cnt", cnt0, 0);
        chk("async_fwd", 32'(fwd0), 32'h11);
        chk("async_cnt2", 32'(cnt2), 0);
        @(negedge clk);
        #1 chk("rst_hold_busy", 32'(busy0), 0);
        rst = 1'b1;
        #1;
        chk("rel_stall", 32'(stall0), 0);
        chk("rel_fwd", 32'(fwd0), 32'h11);
        @(negedge clk);
        #1 chk("rel_first_load", 32'(busy0), 32'b001);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
